// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : 6-stage pipeline hazard controller: load-use, EX-busy and memory
//            wait stalls, bus timeout error, and deferred jump flush.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_is_load_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_rs1_re_i,
    input  logic        id_rs2_re_i,
    input  logic        ex_busy_i,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic [5:0]  stall_o,
    output logic        flush_jump_o,
    output logic [31:0] jump_addr_o,
    output logic        bus_err_o
);

    localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [5:0] C_STALL_MEM    = 6'b011111;
    localparam logic [5:0] C_STALL_EX     = 6'b001111;
    localparam logic [5:0] C_STALL_LU     = 6'b000111;
    localparam logic [5:0] C_STALL_NONE   = 6'b000000;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_bus_err;
    logic        r_jump_pend;
    logic [31:0] r_jump_addr;

    logic        w_timeout_hit;
    logic        w_mem_wait;
    logic        w_rs1_hit;
    logic        w_rs2_hit;
    logic        w_load_use;
    logic [5:0]  w_stall_pri;
    logic        w_flush;

    always_comb begin
        w_timeout_hit = (r_state == S_WAIT) && (r_wait_cnt == C_TIMEOUT_LAST);
        w_mem_wait    = mem_req_i && !mem_ack_i && !w_timeout_hit;
        w_rs1_hit     = id_rs1_re_i && (id_rs1_i == ex_rd_i);
        w_rs2_hit     = id_rs2_re_i && (id_rs2_i == ex_rd_i);
        w_load_use    = ex_is_load_i && (ex_rd_i != 5'd0) && (w_rs1_hit || w_rs2_hit);
    end

    always_comb begin
        w_stall_pri = C_STALL_NONE;
        if (w_mem_wait) begin
            w_stall_pri = C_STALL_MEM;
        end else if (ex_busy_i) begin
            w_stall_pri = C_STALL_EX;
        end else if (w_load_use) begin
            w_stall_pri = C_STALL_LU;
        end
    end

    // A flush can only leave while EX is free; a fresh request beats the pending one.
    always_comb begin
        w_flush      = !rst_i && !w_stall_pri[3] && (jump_req_i || r_jump_pend);
        flush_jump_o = w_flush;
        jump_addr_o  = '0;
        if (w_flush) begin
            jump_addr_o = jump_req_i ? jump_addr_i : r_jump_addr;
        end
        stall_o = w_stall_pri;
        if (rst_i) begin
            stall_o = C_STALL_NONE;
        end else if (w_flush) begin
            stall_o = {w_stall_pri[5:3], 3'b000};
        end
    end

    assign bus_err_o = r_bus_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
            r_bus_err  <= 1'b0;
        end else begin
            r_bus_err <= w_timeout_hit;
            case (r_state)
                S_IDLE: begin
                    r_wait_cnt <= 8'd0;
                    if (w_mem_wait) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack_i || !mem_req_i || w_timeout_hit) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_jump_pend <= 1'b0;
            r_jump_addr <= 32'd0;
        end else if (w_flush) begin
            r_jump_pend <= 1'b0;
        end else if (jump_req_i) begin
            r_jump_pend <= 1'b1;
            r_jump_addr <= jump_addr_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Self-checking bench for pipe_ctrl: directed scenarios plus
//            randomized traffic against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_is_load_i;
    logic [4:0]  ex_rd_i, id_rs1_i, id_rs2_i;
    logic        id_rs1_re_i, id_rs2_re_i;
    logic        ex_busy_i, jump_req_i;
    logic [31:0] jump_addr_i;
    logic        mem_req_i, mem_ack_i;
    logic [5:0]  stall_o;
    logic        flush_jump_o;
    logic [31:0] jump_addr_o;
    logic        bus_err_o;

    int total = 0;
    int bad   = 0;

    // Model state: how many consecutive cycles the current request has stalled.
    int          m_age;
    bit          m_pend;
    logic [31:0] m_pend_addr;
    bit          m_err;
    bit          m_hit, m_mw, m_flush;
    logic [39:0] got, exp;

    always #5 clk_i = ~clk_i;

    pipe_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
        .ex_busy_i(ex_busy_i), .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .stall_o(stall_o), .flush_jump_o(flush_jump_o),
        .jump_addr_o(jump_addr_o), .bus_err_o(bus_err_o)
    );

    task automatic clear_inputs();
        ex_is_load_i = 0; ex_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
        id_rs1_re_i = 0; id_rs2_re_i = 0; ex_busy_i = 0; jump_req_i = 0;
        jump_addr_i = 0; mem_req_i = 0; mem_ack_i = 0;
    endtask

    task automatic model_reset();
        m_age = 0; m_pend = 0; m_pend_addr = 0; m_err = 0;
    endtask

    task automatic model_eval();
        bit lu;
        logic [5:0]  e_stall;
        logic [31:0] e_addr;
        m_hit   = (m_age == TIMEOUT);
        m_mw    = mem_req_i && !mem_ack_i && !m_hit;
        lu      = ex_is_load_i && (ex_rd_i != 0) &&
                  ((id_rs1_re_i && id_rs1_i == ex_rd_i) || (id_rs2_re_i && id_rs2_i == ex_rd_i));
        m_flush = !(m_mw || ex_busy_i) && (jump_req_i || m_pend);
        e_addr  = !m_flush ? 32'd0 : (jump_req_i ? jump_addr_i : m_pend_addr);
        if (m_mw)                  e_stall = 6'b011111;
        else if (ex_busy_i)        e_stall = 6'b001111;
        else if (lu && !m_flush)   e_stall = 6'b000111;
        else                       e_stall = 6'b000000;
        exp = {e_stall, m_flush, e_addr, m_err};
    endtask

    task automatic model_commit();
        m_err = m_hit;
        m_age = m_mw ? m_age + 1 : 0;
        if (m_flush) m_pend = 0;
        else if (jump_req_i) begin
            m_pend = 1; m_pend_addr = jump_addr_i;
        end
    endtask

    // Inputs are driven at posedge+2, outputs sampled at posedge+3.
    task automatic settle();
        #1;
        model_eval();
        got = {stall_o, flush_jump_o, jump_addr_o, bus_err_o};
    endtask

    task automatic next_cycle();
        model_commit();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_cycles(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) begin
            settle();
            next_cycle();
        end
    endtask

    task automatic test_reset();
        rst_i = 1;
        clear_inputs();
        jump_req_i = 1; jump_addr_i = 32'hDEAD_BEEF; mem_req_i = 1; ex_busy_i = 1;
        #3;
        got = {stall_o, flush_jump_o, jump_addr_o, bus_err_o};
        total++;
        if (got !== 40'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=%h", got, 40'd0);
        end
        clear_inputs();
        model_reset();
        @(posedge clk_i); #2;
        rst_i = 0;
        settle();
        total++;
        if (got !== 40'd0 || got !== exp) begin
            bad++; $display("FAIL reset_release got=%h exp=%h", got, exp);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [4:0] rds [3] = '{5'd0, 5'd5, 5'd5};
        logic       re2 [3] = '{1'b1, 1'b1, 1'b0};
        logic [5:0] want[3] = '{6'b000000, 6'b000111, 6'b000000};
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            ex_is_load_i = 1; ex_rd_i = rds[i];
            id_rs2_i = 5; id_rs2_re_i = re2[i];
            id_rs1_i = 7; id_rs1_re_i = 1;
            settle();
            total++;
            if (got !== exp || stall_o !== want[i]) begin
                bad++; $display("FAIL load_use case%0d got=%h exp=%h stall=%b", i, got, exp, want[i]);
            end
            next_cycle();
            clear_inputs();
            settle();
            total++;
            if (got !== exp || stall_o !== 6'b0) begin
                bad++; $display("FAIL load_use_release case%0d got=%h exp=%h", i, got, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_wait();
        clear_inputs();
        for (int c = 0; c < 5; c++) begin
            mem_req_i = (c < 4);
            mem_ack_i = (c == 3);
            settle();
            total++;
            if (got !== exp || stall_o !== ((c < 3) ? 6'b011111 : 6'b0) || bus_err_o !== 1'b0) begin
                bad++; $display("FAIL mem_wait c%0d got=%h exp=%h", c, got, exp);
            end
            next_cycle();
        end
        idle_cycles(2);
    endtask

    task automatic test_timeout();
        clear_inputs();
        for (int c = 0; c < TIMEOUT + 3; c++) begin
            mem_req_i = (c <= TIMEOUT);
            settle();
            total++;
            if (got !== exp || stall_o !== ((c < TIMEOUT) ? 6'b011111 : 6'b0) ||
                bus_err_o !== (c == TIMEOUT + 1)) begin
                bad++; $display("FAIL timeout c%0d got=%h exp=%h", c, got, exp);
            end
            next_cycle();
        end
        idle_cycles(2);
    endtask

    task automatic test_jump_under_stall();
        logic [31:0] want_addr [4] = '{32'd0, 32'd0, 32'h8000_0040, 32'd0};
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            ex_busy_i   = (c < 2);
            jump_req_i  = (c == 0);
            jump_addr_i = (c == 0) ? 32'h8000_0040 : 32'h1234_5678;
            settle();
            total++;
            if (got !== exp || flush_jump_o !== (c == 2) || jump_addr_o !== want_addr[c]) begin
                bad++; $display("FAIL jump_under_stall c%0d got=%h exp=%h", c, got, exp);
            end
            next_cycle();
        end
        // A new request in the flush cycle overrides the pending target.
        clear_inputs();
        ex_busy_i = 1; jump_req_i = 1; jump_addr_i = 32'h0000_1000;
        settle();
        next_cycle();
        ex_busy_i = 0; jump_req_i = 1; jump_addr_i = 32'h0000_2000;
        settle();
        total++;
        if (got !== exp || flush_jump_o !== 1'b1 || jump_addr_o !== 32'h0000_2000) begin
            bad++; $display("FAIL jump_override got=%h exp=%h", got, exp);
        end
        next_cycle();
        clear_inputs();
        settle();
        total++;
        if (got !== exp || flush_jump_o !== 1'b0) begin
            bad++; $display("FAIL jump_pend_cleared got=%h exp=%h", got, exp);
        end
        next_cycle();
    endtask

    task automatic test_jump_with_load_use();
        clear_inputs();
        ex_is_load_i = 1; ex_rd_i = 9; id_rs1_i = 9; id_rs1_re_i = 1;
        jump_req_i = 1; jump_addr_i = $urandom;
        settle();
        total++;
        if (got !== exp || flush_jump_o !== 1'b1 || stall_o !== 6'b0 || jump_addr_o !== jump_addr_i) begin
            bad++; $display("FAIL jump_load_use got=%h exp=%h", got, exp);
        end
        next_cycle();
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        mem_req_i = 1;
        settle(); next_cycle();
        ex_busy_i = 1; jump_req_i = 1; jump_addr_i = 32'hCAFE_0000;
        settle(); next_cycle();
        jump_req_i = 0;
        settle();
        total++;
        if (got !== exp || stall_o !== 6'b011111) begin
            bad++; $display("FAIL mid_wait_pre got=%h exp=%h", got, exp);
        end
        #1 rst_i = 1;
        #1;
        got = {stall_o, flush_jump_o, jump_addr_o, bus_err_o};
        total++;
        if (got !== 40'd0) begin
            bad++; $display("FAIL mid_wait_async_reset got=%h exp=%h", got, 40'd0);
        end
        model_reset();
        ex_busy_i = 0;
        @(posedge clk_i); #2;
        rst_i = 0;
        for (int c = 0; c < TIMEOUT + 3; c++) begin
            mem_req_i = (c <= TIMEOUT);
            settle();
            total++;
            if (got !== exp || flush_jump_o !== 1'b0 || stall_o !== ((c < TIMEOUT) ? 6'b011111 : 6'b0) ||
                bus_err_o !== (c == TIMEOUT + 1)) begin
                bad++; $display("FAIL after_reset_timeout c%0d got=%h exp=%h", c, got, exp);
            end
            next_cycle();
        end
        idle_cycles(2);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ex_is_load_i = ($urandom_range(0, 1) == 1);
            ex_rd_i      = 5'($urandom_range(0, 3));
            id_rs1_i     = 5'($urandom_range(0, 3));
            id_rs2_i     = 5'($urandom_range(0, 3));
            id_rs1_re_i  = ($urandom_range(0, 1) == 1);
            id_rs2_re_i  = ($urandom_range(0, 1) == 1);
            ex_busy_i    = ($urandom_range(0, 4) == 0);
            jump_req_i   = ($urandom_range(0, 5) == 0);
            jump_addr_i  = $urandom;
            mem_req_i    = ($urandom_range(0, 3) != 0);
            mem_ack_i    = ($urandom_range(0, 3) == 0);
            settle();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL random c%0d got=%h exp=%h", c, got, exp);
            end
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_i = 1;
        clear_inputs();
        model_reset();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_jump_under_stall();
        test_jump_with_load_use();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of consecutive memory-wait cycles before the wait is abandoned (range 2..255).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port ex_is_load_i, input, 1 bit: the instruction held in the ID/EX register is a load.
REQ-005 SHALL have port ex_rd_i, input, 5 bits: destination register of the ID/EX instruction.
REQ-006 SHALL have port id_rs1_i and port id_rs2_i, input, 5 bits each: source registers of the instruction in ID.
REQ-007 SHALL have port id_rs1_re_i and port id_rs2_re_i, input, 1 bit each: the instruction in ID reads rs1 / rs2.
REQ-008 SHALL have port ex_busy_i, input, 1 bit: a multi-cycle operation in EX is not finished.
REQ-009 SHALL have port jump_req_i, input, 1 bit: EX resolves a taken jump or branch this cycle.
REQ-010 SHALL have port jump_addr_i, input, 32 bits: the target of that jump.
REQ-011 SHALL have port mem_req_i and port mem_ack_i, input, 1 bit each: the MEM-stage bus request and its acknowledge.
REQ-012 SHALL have port stall_o, output, 6 bits: per-stage stop (1 = stop); bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-013 SHALL have port flush_jump_o, output, 1 bit: squash the IF/ID and ID/EX contents.
REQ-014 SHALL have port jump_addr_o, output, 32 bits: redirect target, valid while flush_jump_o=1.
REQ-015 SHALL have port bus_err_o, output, 1 bit: one-cycle pulse when a memory wait times out.

Function
REQ-016 SHALL detect a load-use hazard when ex_is_load_i=1, ex_rd_i!=0, and ((id_rs1_re_i and id_rs1_i==ex_rd_i) or (id_rs2_re_i and id_rs2_i==ex_rd_i)).
REQ-017 SHALL combinationally select stall_o by priority: memory wait 6'b011111, then ex_busy_i 6'b001111, then load-use 6'b000111, otherwise 6'b000000.
REQ-018 SHALL define memory wait as mem_req_i=1 and mem_ack_i=0 and the timeout-hit condition false; it stalls in the same cycle as the request (zero latency).
REQ-019 SHALL implement the bus FSM with states IDLE and WAIT.
- IDLE goes to WAIT on a memory wait.
- WAIT goes to IDLE on mem_ack_i=1, on mem_req_i=0, or on timeout.
REQ-020 SHALL count cycles in WAIT with an 8-bit counter, cleared on entry to IDLE; timeout-hit is defined as WAIT and counter==TIMEOUT-1.
REQ-021 SHALL, on timeout-hit, release the memory-wait stall in that cycle, register bus_err_o=1 for exactly the next cycle, and return to IDLE.
REQ-022 SHALL assert flush_jump_o and drive jump_addr_o=jump_addr_i in the same cycle when jump_req_i=1 and stall_o[3]=0.
REQ-023 SHALL, when jump_req_i=1 while stall_o[3]=1, latch a pending jump and its address, keep flush_jump_o=0 during the stall, and assert flush_jump_o with the latched address for one cycle in the first cycle stall_o[3]=0.
REQ-024 SHALL clear the pending jump in the cycle its flush is issued.
- A new jump_req_i in that same cycle takes precedence: its address is driven and pending is cleared.
REQ-025 SHALL force stall_o[2:0]=0 in any cycle where flush_jump_o=1, so the squashed ID instruction cannot hold a load-use stall.
REQ-026 SHALL treat ex_rd_i==0 as never hazardous, and SHALL ignore id_rs*_i when the matching re bit is 0.
REQ-027 SHALL drive jump_addr_o=0 whenever flush_jump_o=0.

Reset
REQ-028 SHALL, while rst_i=1, immediately and asynchronously set: stall_o=0, flush_jump_o=0, jump_addr_o=0, bus_err_o=0, FSM=IDLE, counter=0, pending cleared.
REQ-029 SHALL, on reset asserted mid-WAIT or with a jump pending, discard that state; the first cycle after release behaves as IDLE with nothing pending.

Verification
REQ-030 SHALL cover load-use: ex_is_load_i=1, ex_rd_i=5, id_rs2_i=5, id_rs2_re_i=1 -> stall_o=6'b000111 for one cycle; the same stimulus with ex_rd_i=0 -> stall_o=0.
REQ-031 SHALL cover memory wait: mem_req_i=1 with mem_ack_i rising after 3 cycles -> stall_o=6'b011111 for 3 cycles, then 0, and bus_err_o stays 0.
REQ-032 SHALL cover timeout: TIMEOUT=4, mem_req_i=1 held with no ack -> stall for 4 cycles, then stall_o=0 and bus_err_o=1 for exactly 1 cycle.
REQ-033 SHALL cover jump under stall: ex_busy_i=1 for 2 cycles with jump_req_i=1, addr 0x80000040 in cycle 1 -> no flush while busy, then flush_jump_o=1, jump_addr_o=0x80000040 for one cycle after busy drops.
REQ-034 SHALL cover jump with load-use in the same cycle: jump_req_i=1 and the load-use condition true -> flush_jump_o=1, stall_o=0.
REQ-035 SHALL cover reset mid-WAIT: rst_i pulsed in the 2nd WAIT cycle -> all outputs 0 asynchronously, and a new request afterwards times out after the full TIMEOUT.
